// File: rtl/tx_pkt_pkg.sv
// rtl/tx_pkt_pkg.sv - shared constants, state encoding and helpers for the TX packet framer
package tx_pkt_pkg;

  localparam int MAX_WORDS = 15;
  localparam int WORD_W    = 16;
  localparam int BUF_DEPTH = MAX_WORDS + 1;

  localparam int HDR_TYPE_MSB = 7;
  localparam int HDR_TYPE_LSB = 4;
  localparam int HDR_CNT_MSB  = 3;
  localparam int HDR_CNT_LSB  = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DHI   = 3'd2;
  localparam logic [2:0] ST_DLO   = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_GUARD = 3'd5;

  function automatic logic [7:0] make_header(input logic [3:0] rtype, input logic [3:0] cnt);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_TYPE_MSB:HDR_TYPE_LSB] = rtype;
    h[HDR_CNT_MSB:HDR_CNT_LSB]   = cnt;
    return h;
  endfunction

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/tx_word_buffer.sv
// rtl/tx_word_buffer.sv - 16x16 response word register file, sync write, async read
module tx_word_buffer
  import tx_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [3:0]        rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/tx_packet_framer.sv
// rtl/tx_packet_framer.sv - frames buffered response words into header/data/checksum UART bytes
module tx_packet_framer
  import tx_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_word,
  input  logic              write_tx_word,
  input  logic              new_tx_dv,
  input  logic [3:0]        tx_word_cnt,
  input  logic [3:0]        tx_resp_type,
  output logic              tx_busy,
  output logic              tx_err,
  output logic              tx_ovf,
  output logic [7:0]        uart_data,
  output logic              uart_new_data,
  input  logic              uart_busy,
  input  logic              uart_block
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_WORDS);

  logic [2:0]        state;
  logic [2:0]        ret_state;
  logic [3:0]        wr_ptr;
  logic [3:0]        rd_ptr;
  logic [3:0]        cnt_q;
  logic [3:0]        type_q;
  logic [7:0]        checksum;
  logic [7:0]        cur_byte;
  logic [WORD_W-1:0] rd_word;
  logic              wr_accept;
  logic [4:0]        avail;
  logic              issue_ok;

  assign wr_accept = write_tx_word && !tx_busy && ({1'b0, wr_ptr} < MAX_CNT);
  // A write in the same cycle as the request is counted before the count check.
  assign avail     = {1'b0, wr_ptr} + {4'b0000, wr_accept};
  assign issue_ok  = !uart_busy && !uart_block;

  tx_word_buffer u_buf (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_idx  (wr_ptr),
    .wr_data (tx_word),
    .rd_idx  (rd_ptr),
    .rd_data (rd_word)
  );

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      ST_HDR:  cur_byte = make_header(type_q, cnt_q);
      ST_DHI:  cur_byte = rd_word[15:8];
      ST_DLO:  cur_byte = rd_word[7:0];
      ST_CHK:  cur_byte = checksum;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ret_state     <= ST_IDLE;
      wr_ptr        <= 4'd0;
      rd_ptr        <= 4'd0;
      cnt_q         <= 4'd0;
      type_q        <= 4'd0;
      checksum      <= 8'h00;
      tx_busy       <= 1'b0;
      tx_err        <= 1'b0;
      tx_ovf        <= 1'b0;
      uart_data     <= 8'h00;
      uart_new_data <= 1'b0;
    end else begin
      uart_new_data <= 1'b0;
      tx_err        <= 1'b0;

      if (wr_accept) wr_ptr <= wr_ptr + 4'd1;
      if (new_tx_dv && state == ST_IDLE) tx_ovf <= 1'b0;
      // A drop in the request cycle wins over the clear.
      if (write_tx_word && !wr_accept) tx_ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (new_tx_dv) begin
            cnt_q  <= tx_word_cnt;
            type_q <= tx_resp_type;
            if ({1'b0, tx_word_cnt} > avail) begin
              tx_err <= 1'b1;
              wr_ptr <= 4'd0;
            end else begin
              tx_busy <= 1'b1;
              rd_ptr  <= 4'd0;
              state   <= ST_HDR;
            end
          end
        end

        ST_GUARD: begin
          state <= ret_state;
          if (ret_state == ST_IDLE) begin
            tx_busy <= 1'b0;
            wr_ptr  <= 4'd0;
            rd_ptr  <= 4'd0;
          end
        end

        ST_HDR, ST_DHI, ST_DLO, ST_CHK: begin
          if (issue_ok) begin
            uart_new_data <= 1'b1;
            uart_data     <= cur_byte;
            state         <= ST_GUARD;
            case (state)
              ST_HDR: begin
                checksum  <= chk_update(8'h00, cur_byte);
                ret_state <= (cnt_q != 4'd0) ? ST_DHI : ST_CHK;
              end
              ST_DHI: begin
                checksum  <= chk_update(checksum, cur_byte);
                ret_state <= ST_DLO;
              end
              ST_DLO: begin
                checksum  <= chk_update(checksum, cur_byte);
                rd_ptr    <= rd_ptr + 4'd1;
                ret_state <= (({1'b0, rd_ptr} + 5'd1) < {1'b0, cnt_q}) ? ST_DHI : ST_CHK;
              end
              default: ret_state <= ST_IDLE;
            endcase
          end
        end

        default: begin
          state   <= ST_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb/tb_tx_packet_framer.sv - directed self-checking bench for tx_packet_framer
module tb_tx_packet_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_word = 16'h0000;
  logic        write_tx_word = 1'b0;
  logic        new_tx_dv = 1'b0;
  logic [3:0]  tx_word_cnt = 4'd0;
  logic [3:0]  tx_resp_type = 4'd0;
  logic        tx_busy;
  logic        tx_err;
  logic        tx_ovf;
  logic [7:0]  uart_data;
  logic        uart_new_data;
  logic        uart_busy = 1'b0;
  logic        uart_block = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int err_seen = 0;
  bit uart_model_en = 1'b0;
  int bcnt = 0;
  logic [7:0] bq[$];
  int tq[$];

  tx_packet_framer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_word       (tx_word),
    .write_tx_word (write_tx_word),
    .new_tx_dv     (new_tx_dv),
    .tx_word_cnt   (tx_word_cnt),
    .tx_resp_type  (tx_resp_type),
    .tx_busy       (tx_busy),
    .tx_err        (tx_err),
    .tx_ovf        (tx_ovf),
    .uart_data     (uart_data),
    .uart_new_data (uart_new_data),
    .uart_busy     (uart_busy),
    .uart_block    (uart_block)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture: strobes are one full cycle wide, so each is seen at exactly one falling edge.
  initial forever begin
    @(negedge clk);
    if (uart_new_data === 1'b1) begin
      bq.push_back(uart_data);
      tq.push_back(cyc);
    end
    if (tx_err === 1'b1) err_seen++;
  end

  // UART model: busy for four falling edges after each strobe.
  initial forever begin
    @(negedge clk);
    if (uart_model_en && uart_new_data === 1'b1) begin
      uart_busy = 1'b1;
      bcnt = 4;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) uart_busy = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] w);
    tick();
    tx_word = w;
    write_tx_word = 1'b1;
    tick();
    write_tx_word = 1'b0;
  endtask

  task automatic do_send(input logic [3:0] c, input logic [3:0] t, output int rc);
    tick();
    tx_word_cnt = c;
    tx_resp_type = t;
    new_tx_dv = 1'b1;
    rc = cyc;
    tick();
    new_tx_dv = 1'b0;
  endtask

  task automatic wait_idle(output int end_cyc);
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (tx_busy !== 1'b0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_idle: tx_busy=%b after %0d cycles, required 0", tx_busy, n);
    end
    end_cyc = cyc;
  endtask

  task automatic wait_bytes(input int want);
    int n;
    n = 0;
    while (bq.size() < want && n < 200) begin
      tick();
      n++;
    end
    if (bq.size() < want) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_bytes: got %0d bytes, required %0d", bq.size(), want);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
    tests_run++; if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b, required 0", tx_err); end
    tests_run++; if (tx_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b, required 0", tx_ovf); end
    tests_run++; if (uart_new_data !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe: got %b, required 0", uart_new_data); end
    tests_run++; if (uart_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h, required 00", uart_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [6] = '{8'h32, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h72};
    int rc, ec;
    bq.delete(); tq.delete();
    do_write(16'h1234);
    do_write(16'hABCD);
    do_send(4'd2, 4'd3, rc);
    tests_run++; if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_rise: got %b, required 1", tx_busy); end
    wait_idle(ec);
    tests_run++;
    if (bq.size() != 6) begin
      tests_failed++; $display("FAIL basic_len: got %0d bytes, required 6", bq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (bq[i] !== exp[i]) begin tests_failed++; $display("FAIL basic_byte%0d: got %h, required %h", i, bq[i], exp[i]); end
      end
      tests_run++; if (tq[0] - rc != 2) begin tests_failed++; $display("FAIL basic_latency: got %0d, required 2", tq[0] - rc); end
      tests_run++; if (ec != tq[5] + 1) begin tests_failed++; $display("FAIL basic_busy_fall: got cycle %0d, required %0d", ec, tq[5] + 1); end
    end
  endtask

  task automatic test_empty();
    int rc, ec;
    bq.delete(); tq.delete();
    do_send(4'd0, 4'hF, rc);
    wait_idle(ec);
    tests_run++;
    if (bq.size() != 2) begin
      tests_failed++; $display("FAIL empty_len: got %0d bytes, required 2", bq.size());
    end else begin
      tests_run++; if (bq[0] !== 8'hF0) begin tests_failed++; $display("FAIL empty_hdr: got %h, required f0", bq[0]); end
      tests_run++; if (bq[1] !== 8'hF0) begin tests_failed++; $display("FAIL empty_chk: got %h, required f0", bq[1]); end
      tests_run++; if (tq[0] - rc != 2) begin tests_failed++; $display("FAIL empty_latency: got %0d, required 2", tq[0] - rc); end
    end
  endtask

  task automatic test_error();
    int rc, ec;
    bq.delete(); tq.delete();
    do_write(16'h5555);
    do_send(4'd2, 4'd1, rc);
    tests_run++; if (tx_err !== 1'b1) begin tests_failed++; $display("FAIL err_pulse: got %b, required 1", tx_err); end
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL err_busy: got %b, required 0", tx_busy); end
    tick();
    tests_run++; if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL err_one_cycle: got %b, required 0", tx_err); end
    repeat (5) tick();
    tests_run++; if (bq.size() != 0) begin tests_failed++; $display("FAIL err_no_bytes: got %0d bytes, required 0", bq.size()); end
    do_send(4'd1, 4'd5, rc);
    tests_run++; if (tx_err !== 1'b1) begin tests_failed++; $display("FAIL err_buffer_cleared: got tx_err=%b, required 1", tx_err); end
    do_send(4'd0, 4'd5, rc);
    wait_idle(ec);
    tests_run++;
    if (bq.size() != 2) begin
      tests_failed++; $display("FAIL err_followup_len: got %0d bytes, required 2", bq.size());
    end else begin
      tests_run++; if (bq[0] !== 8'h50 || bq[1] !== 8'h50) begin tests_failed++; $display("FAIL err_followup_bytes: got %h %h, required 50 50", bq[0], bq[1]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [32];
    int rc, ec;
    exp[0] = 8'h2F;
    for (int i = 0; i < 15; i++) begin
      exp[1 + 2 * i] = 8'h01;
      exp[2 + 2 * i] = 8'(i);
    end
    exp[31] = 8'h21;
    bq.delete(); tq.delete();
    for (int i = 0; i < 15; i++) do_write(16'h0100 + 16'(i));
    tests_run++; if (tx_ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_after15: got %b, required 0", tx_ovf); end
    do_write(16'hFFFF);
    tests_run++; if (tx_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_after16: got %b, required 1", tx_ovf); end
    do_send(4'd15, 4'd2, rc);
    tests_run++; if (tx_ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_cleared_by_req: got %b, required 0", tx_ovf); end
    do_write(16'h7777);
    tests_run++; if (tx_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_busy_write: got %b, required 1", tx_ovf); end
    wait_idle(ec);
    tests_run++;
    if (bq.size() != 32) begin
      tests_failed++; $display("FAIL ovf_len: got %0d bytes, required 32", bq.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        tests_run++;
        if (bq[i] !== exp[i]) begin tests_failed++; $display("FAIL ovf_byte%0d: got %h, required %h", i, bq[i], exp[i]); end
      end
    end
    bq.delete(); tq.delete();
    do_send(4'd0, 4'd0, rc);
    tests_run++; if (tx_ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_next_req_clear: got %b, required 0", tx_ovf); end
    wait_idle(ec);
    tests_run++; if (bq.size() != 2) begin tests_failed++; $display("FAIL ovf_next_len: got %0d bytes, required 2", bq.size()); end
  endtask

  task automatic test_block();
    logic [7:0] exp [6] = '{8'h72, 8'hC3, 8'hA5, 8'h0F, 8'h0E, 8'h15};
    int rc, ec;
    bq.delete(); tq.delete();
    do_write(16'hC3A5);
    do_write(16'h0F0E);
    do_send(4'd2, 4'd7, rc);
    wait_bytes(2);
    uart_block = 1'b1;
    repeat (50) tick();
    tests_run++; if (bq.size() != 2) begin tests_failed++; $display("FAIL block_hold: got %0d bytes while blocked, required 2", bq.size()); end
    tests_run++; if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL block_busy: got %b, required 1", tx_busy); end
    uart_block = 1'b0;
    wait_idle(ec);
    tests_run++;
    if (bq.size() != 6) begin
      tests_failed++; $display("FAIL block_len: got %0d bytes, required 6", bq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (bq[i] !== exp[i]) begin tests_failed++; $display("FAIL block_byte%0d: got %h, required %h", i, bq[i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [6] = '{8'h62, 8'h3C, 8'h3C, 8'h00, 8'h01, 8'h63};
    int rc, ec;
    bq.delete(); tq.delete();
    do_write(16'h1111);
    do_write(16'h2222);
    do_send(4'd2, 4'd4, rc);
    wait_bytes(2);
    uart_block = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b, required 0", tx_busy); end
    tests_run++; if (uart_new_data !== 1'b0) begin tests_failed++; $display("FAIL rstmid_strobe: got %b, required 0", uart_new_data); end
    tests_run++; if (uart_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h, required 00", uart_data); end
    uart_block = 1'b0;
    repeat (3) tick();
    tests_run++; if (bq.size() != 2) begin tests_failed++; $display("FAIL rstmid_no_strobe: got %0d bytes, required 2", bq.size()); end
    rst_n = 1'b1;
    tick();
    bq.delete(); tq.delete();
    do_write(16'h3C3C);
    do_write(16'h0001);
    do_send(4'd2, 4'd6, rc);
    wait_idle(ec);
    tests_run++;
    if (bq.size() != 6) begin
      tests_failed++; $display("FAIL rstmid_len: got %0d bytes, required 6", bq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (bq[i] !== exp[i]) begin tests_failed++; $display("FAIL rstmid_byte%0d: got %h, required %h", i, bq[i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h12, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h30, 8'hA0, 8'hA0};
    int rc, ec, err0;
    bq.delete(); tq.delete();
    uart_model_en = 1'b1;
    err0 = err_seen;
    do_write(16'hDEAD);
    do_write(16'hBEEF);
    do_send(4'd2, 4'd1, rc);
    repeat (3) tick();
    tx_word_cnt = 4'd15;
    new_tx_dv = 1'b1;
    tick();
    new_tx_dv = 1'b0;
    wait_idle(ec);
    do_send(4'd0, 4'hA, rc);
    wait_idle(ec);
    uart_model_en = 1'b0;
    repeat (6) tick();
    tests_run++; if (err_seen != err0) begin tests_failed++; $display("FAIL b2b_ignored_req: got %0d err pulses, required 0", err_seen - err0); end
    tests_run++;
    if (bq.size() != 8) begin
      tests_failed++; $display("FAIL b2b_len: got %0d bytes, required 8", bq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (bq[i] !== exp[i]) begin tests_failed++; $display("FAIL b2b_byte%0d: got %h, required %h", i, bq[i], exp[i]); end
      end
      for (int i = 1; i < 6; i++) begin
        tests_run++;
        if (tq[i] - tq[i-1] < 5) begin tests_failed++; $display("FAIL b2b_gap%0d: got %0d cycles, required >= 5", i, tq[i] - tq[i-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_error();
    test_overflow();
    test_block();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
